// File: rtl/tu_op_if.sv
// Purpose : TU op channel between the op sequencer (master) and the translation unit (slave).
// Latency : pure wiring, no state.
// Backpressure: request side is valid/ready; response is a single-cycle resp_valid pulse, no ready.
//
// Ports (signals):
//   req_valid/req_ready              request handshake
//   req_kind, req_index              op kind (0=TLBP 1=TLBR 2=TLBWI 3=TLBWR) and target index
//   req_entryhi/entrylo0/entrylo1    entry operands for writes / probe key
//   resp_valid                       response pulse
//   resp_hit, resp_index             TLBP result
//   resp_entryhi/entrylo0/entrylo1   TLBR read data
interface tu_op_if #(
    parameter int IDX_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_kind;
    logic [IDX_W-1:0] req_index;
    logic [31:0]      req_entryhi;
    logic [31:0]      req_entrylo0;
    logic [31:0]      req_entrylo1;
    logic             resp_valid;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_index;
    logic [31:0]      resp_entryhi;
    logic [31:0]      resp_entrylo0;
    logic [31:0]      resp_entrylo1;

    modport master (
        output req_valid, req_kind, req_index, req_entryhi, req_entrylo0, req_entrylo1,
        input  req_ready,
        input  resp_valid, resp_hit, resp_index, resp_entryhi, resp_entrylo0, resp_entrylo1
    );

    modport slave (
        input  req_valid, req_kind, req_index, req_entryhi, req_entrylo0, req_entrylo1,
        output req_ready,
        output resp_valid, resp_hit, resp_index, resp_entryhi, resp_entrylo0, resp_entrylo1
    );
endinterface

// File: rtl/tu_op_sequencer.sv
// Purpose : initiator for TLBP/TLBR/TLBWI/TLBWR: issues a TU request, waits for the response,
//           commits results to CP0; also owns the CP0 Random/Wired pair.
// Latency : accept -> op_done is 3 cycles minimum (ready in first REQ cycle, response next cycle).
// Backpressure: holds the request payload stable until req_ready; stalls the pipeline with op_busy
//           from acceptance until the commit cycle. No timeout on the response.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   op_valid, op_kind, flush         op from MEM stage; flush blocks acceptance only in IDLE
//   op_busy, op_done                 pipeline stall; single-cycle commit pulse
//   cp0_entryhi/entrylo0/entrylo1    CP0 operands latched at acceptance
//   cp0_index                        Index used by TLBWI
//   cp0_wired, wired_we              Wired write port
//   random                           CP0 Random
//   tu                               TU op channel (master side)
//   wr_index, wr_index_data          CP0 Index write (TLBP)
//   wr_entry, wr_entryhi/lo0/lo1     CP0 EntryHi/Lo0/Lo1 write (TLBR)
module tu_op_sequencer #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op_kind,
    input  logic             flush,
    output logic             op_busy,
    output logic             op_done,
    input  logic [31:0]      cp0_entryhi,
    input  logic [31:0]      cp0_entrylo0,
    input  logic [31:0]      cp0_entrylo1,
    input  logic [IDX_W-1:0] cp0_index,
    input  logic [IDX_W-1:0] cp0_wired,
    input  logic             wired_we,
    output logic [IDX_W-1:0] random,
    tu_op_if.master          tu,
    output logic             wr_index,
    output logic [31:0]      wr_index_data,
    output logic             wr_entry,
    output logic [31:0]      wr_entryhi,
    output logic [31:0]      wr_entrylo0,
    output logic [31:0]      wr_entrylo1
);

    localparam logic [1:0] KIND_TLBP  = 2'd0;
    localparam logic [1:0] KIND_TLBR  = 2'd1;
    localparam logic [1:0] KIND_TLBWI = 2'd2;
    localparam logic [1:0] KIND_TLBWR = 2'd3;

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t           state_q,        state_d;
    logic             req_valid_q,    req_valid_d;
    logic [1:0]       req_kind_q,     req_kind_d;
    logic [IDX_W-1:0] req_index_q,    req_index_d;
    logic [31:0]      req_entryhi_q,  req_entryhi_d;
    logic [31:0]      req_entrylo0_q, req_entrylo0_d;
    logic [31:0]      req_entrylo1_q, req_entrylo1_d;
    logic             op_done_q,      op_done_d;
    logic             wr_index_q,     wr_index_d;
    logic [31:0]      wr_index_data_q, wr_index_data_d;
    logic             wr_entry_q,     wr_entry_d;
    logic [31:0]      wr_entryhi_q,   wr_entryhi_d;
    logic [31:0]      wr_entrylo0_q,  wr_entrylo0_d;
    logic [31:0]      wr_entrylo1_q,  wr_entrylo1_d;
    logic [IDX_W-1:0] random_q,       random_d;
    logic [IDX_W-1:0] wired_q,        wired_d;

    logic accept;

    // Acceptance is the only combinational path to op_busy: the pipeline must stall in the
    // same cycle the op is taken, before any state has changed.
    assign accept  = (state_q == S_IDLE) && op_valid && !flush;
    assign op_busy = accept || (state_q == S_REQ) || (state_q == S_WAIT);

    // Op channel FSM and commit data
    always_comb begin
        state_d         = state_q;
        req_valid_d     = req_valid_q;
        req_kind_d      = req_kind_q;
        req_index_d     = req_index_q;
        req_entryhi_d   = req_entryhi_q;
        req_entrylo0_d  = req_entrylo0_q;
        req_entrylo1_d  = req_entrylo1_q;
        op_done_d       = 1'b0;
        wr_index_d      = 1'b0;
        wr_entry_d      = 1'b0;
        wr_index_data_d = wr_index_data_q;
        wr_entryhi_d    = wr_entryhi_q;
        wr_entrylo0_d   = wr_entrylo0_q;
        wr_entrylo1_d   = wr_entrylo1_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d        = S_REQ;
                    req_valid_d    = 1'b1;
                    req_kind_d     = op_kind;
                    req_entryhi_d  = cp0_entryhi;
                    req_entrylo0_d = cp0_entrylo0;
                    req_entrylo1_d = cp0_entrylo1;
                    // TLBWR targets the Random value seen at acceptance, not the one
                    // current when the TU finally takes the request.
                    if (op_kind == KIND_TLBWI)
                        req_index_d = cp0_index;
                    else if (op_kind == KIND_TLBWR)
                        req_index_d = random_q;
                    else
                        req_index_d = '0;
                end
            end
            S_REQ: begin
                if (tu.req_ready) begin
                    state_d     = S_WAIT;
                    req_valid_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (tu.resp_valid) begin
                    state_d         = S_COMMIT;
                    op_done_d       = 1'b1;
                    wr_index_d      = (req_kind_q == KIND_TLBP);
                    wr_entry_d      = (req_kind_q == KIND_TLBR);
                    wr_index_data_d = tu.resp_hit ? 32'(tu.resp_index) : 32'h8000_0000;
                    wr_entryhi_d    = tu.resp_entryhi;
                    wr_entrylo0_d   = tu.resp_entrylo0;
                    wr_entrylo1_d   = tu.resp_entrylo1;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Random / Wired. A Wired at or above the top entry makes the wrap test true every
    // cycle, which pins Random at the top without a separate case.
    always_comb begin
        wired_d  = wired_q;
        random_d = random_q;
        if (wired_we) begin
            wired_d  = cp0_wired;
            random_d = RAND_TOP;
        end else if (random_q <= wired_q) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            req_valid_q     <= 1'b0;
            req_kind_q      <= '0;
            req_index_q     <= '0;
            req_entryhi_q   <= '0;
            req_entrylo0_q  <= '0;
            req_entrylo1_q  <= '0;
            op_done_q       <= 1'b0;
            wr_index_q      <= 1'b0;
            wr_index_data_q <= '0;
            wr_entry_q      <= 1'b0;
            wr_entryhi_q    <= '0;
            wr_entrylo0_q   <= '0;
            wr_entrylo1_q   <= '0;
            random_q        <= RAND_TOP;
            wired_q         <= '0;
        end else begin
            state_q         <= state_d;
            req_valid_q     <= req_valid_d;
            req_kind_q      <= req_kind_d;
            req_index_q     <= req_index_d;
            req_entryhi_q   <= req_entryhi_d;
            req_entrylo0_q  <= req_entrylo0_d;
            req_entrylo1_q  <= req_entrylo1_d;
            op_done_q       <= op_done_d;
            wr_index_q      <= wr_index_d;
            wr_index_data_q <= wr_index_data_d;
            wr_entry_q      <= wr_entry_d;
            wr_entryhi_q    <= wr_entryhi_d;
            wr_entrylo0_q   <= wr_entrylo0_d;
            wr_entrylo1_q   <= wr_entrylo1_d;
            random_q        <= random_d;
            wired_q         <= wired_d;
        end
    end

    assign tu.req_valid    = req_valid_q;
    assign tu.req_kind     = req_kind_q;
    assign tu.req_index    = req_index_q;
    assign tu.req_entryhi  = req_entryhi_q;
    assign tu.req_entrylo0 = req_entrylo0_q;
    assign tu.req_entrylo1 = req_entrylo1_q;

    assign op_done       = op_done_q;
    assign wr_index      = wr_index_q;
    assign wr_index_data = wr_index_data_q;
    assign wr_entry      = wr_entry_q;
    assign wr_entryhi    = wr_entryhi_q;
    assign wr_entrylo0   = wr_entrylo0_q;
    assign wr_entrylo1   = wr_entrylo1_q;
    assign random        = random_q;

endmodule

// File: tb/tb_tu_op_sequencer.sv
// Bench for tu_op_sequencer: acts as MEM stage and as the TU, with a closed-form Random model.
module tb_tu_op_sequencer;
    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic [1:0]    op_kind;
    logic          flush;
    logic          op_busy;
    logic          op_done;
    logic [31:0]   cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
    logic [IW-1:0] cp0_index, cp0_wired;
    logic          wired_we;
    logic [IW-1:0] random;
    logic          wr_index, wr_entry;
    logic [31:0]   wr_index_data, wr_entryhi, wr_entrylo0, wr_entrylo1;

    tu_op_if #(.IDX_W(IW)) tu_bus ();

    tu_op_sequencer #(.TLB_ENTRIES(N), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_kind(op_kind), .flush(flush),
        .op_busy(op_busy), .op_done(op_done), .cp0_entryhi(cp0_entryhi),
        .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index),
        .cp0_wired(cp0_wired), .wired_we(wired_we), .random(random), .tu(tu_bus),
        .wr_index(wr_index), .wr_index_data(wr_index_data), .wr_entry(wr_entry),
        .wr_entryhi(wr_entryhi), .wr_entrylo0(wr_entrylo0), .wr_entrylo1(wr_entrylo1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Random model: cycles since the last reload, and the Wired value in force.
    // Random sweeps TOP down to Wired, so it is TOP minus (n mod period).
    int m_n, m_w;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_n = 0; m_w = 0;
        end else if (wired_we) begin
            m_n = 0; m_w = int'(cp0_wired);
        end else begin
            m_n = m_n + 1;
        end
    end

    function automatic int exp_random();
        if (m_w >= N - 1) return N - 1;
        return (N - 1) - (m_n % (N - m_w));
    endfunction

    // Observations of one op, filled by run_op and judged by the calling test.
    int            o_lat, o_req_cycles, o_rand_acc, e_rand_commit;
    bit            o_stable, o_busy_acc, o_busy_mid, o_busy_commit, o_req_in_wait;
    bit            o_done_after, o_timeout, o_wr_index, o_wr_entry;
    logic [1:0]    o_kind;
    logic [IW-1:0] o_idx, o_rand_commit, e_idx;
    logic [31:0]   o_hi, o_lo0, o_lo1, o_wid, o_whi, o_wlo0, o_wlo1, e_hi, e_lo0, e_lo1;

    task automatic run_op(input logic [1:0] kind, input int rdly, input int sdly,
                          input logic hit, input logic [IW-1:0] ridx,
                          input logic [31:0] rhi, input logic [31:0] rlo0, input logic [31:0] rlo1);
        @(negedge clk);
        op_valid = 1'b1; op_kind = kind; flush = 1'b0;
        e_hi = cp0_entryhi; e_lo0 = cp0_entrylo0; e_lo1 = cp0_entrylo1;
        o_rand_acc = exp_random();
        e_idx = (kind == 2'd2) ? cp0_index : (kind == 2'd3) ? IW'(o_rand_acc) : '0;
        #1 o_busy_acc = op_busy;
        o_lat = 0; o_stable = 1; o_busy_mid = 1; o_req_cycles = 0; o_req_in_wait = 0;
        for (int c = 0; c <= rdly; c++) begin
            @(negedge clk); o_lat++;
            op_valid = 1'b0;
            if (tu_bus.req_valid) o_req_cycles++; else o_stable = 0;
            if (c == 0) begin
                o_kind = tu_bus.req_kind; o_idx = tu_bus.req_index;
                o_hi = tu_bus.req_entryhi; o_lo0 = tu_bus.req_entrylo0; o_lo1 = tu_bus.req_entrylo1;
            end else if (o_kind !== tu_bus.req_kind || o_idx !== tu_bus.req_index ||
                         o_hi !== tu_bus.req_entryhi || o_lo0 !== tu_bus.req_entrylo0 ||
                         o_lo1 !== tu_bus.req_entrylo1) begin
                o_stable = 0;
            end
            o_busy_mid &= op_busy;
            // Operands and flush move while the op is in flight; the DUT must not care.
            cp0_entryhi = $urandom; cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom;
            cp0_index = IW'($urandom); flush = 1'($urandom_range(0, 1));
            tu_bus.req_ready = (c == rdly);
        end
        for (int c = 0; c <= sdly; c++) begin
            @(negedge clk); o_lat++;
            tu_bus.req_ready = 1'b0;
            if (tu_bus.req_valid) o_req_in_wait = 1;
            o_busy_mid &= op_busy;
            tu_bus.resp_valid = (c == sdly);
            tu_bus.resp_hit = (c == sdly) ? hit : 1'($urandom);
            tu_bus.resp_index = (c == sdly) ? ridx : IW'($urandom);
            tu_bus.resp_entryhi = (c == sdly) ? rhi : $urandom;
            tu_bus.resp_entrylo0 = (c == sdly) ? rlo0 : $urandom;
            tu_bus.resp_entrylo1 = (c == sdly) ? rlo1 : $urandom;
        end
        o_timeout = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); o_lat++;
            tu_bus.resp_valid = 1'b0; flush = 1'b0;
            if (op_done) begin
                o_timeout = 0;
                o_busy_commit = op_busy; o_wr_index = wr_index; o_wr_entry = wr_entry;
                o_wid = wr_index_data; o_whi = wr_entryhi; o_wlo0 = wr_entrylo0; o_wlo1 = wr_entrylo1;
                o_rand_commit = random; e_rand_commit = exp_random();
                break;
            end
        end
        @(negedge clk);
        o_done_after = op_done | wr_index | wr_entry;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (random !== 4'd15) begin errors++; $display("FAIL reset_random got %0d expected 15", random); end
        checks++; if ({tu_bus.req_valid, op_busy, op_done, wr_index, wr_entry} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got %b expected 00000", {tu_bus.req_valid, op_busy, op_done, wr_index, wr_entry}); end
        checks++; if ({wr_index_data, wr_entryhi, tu_bus.req_entryhi, tu_bus.req_index} !== '0) begin
            errors++; $display("FAIL reset_data got %0h expected 0", {wr_index_data, wr_entryhi, tu_bus.req_entryhi, tu_bus.req_index}); end
        reset = 1'b0;
    endtask

    task automatic test_tlbp_hit();
        cp0_entryhi = 32'hABCD_E012; cp0_entrylo0 = 32'h1; cp0_entrylo1 = 32'h2;
        run_op(2'd0, 0, 0, 1'b1, 4'd5, 32'h0, 32'h0, 32'h0);
        checks++; if (o_timeout || o_lat != 3) begin errors++; $display("FAIL tlbp_hit_latency got %0d (timeout %0d) expected 3", o_lat, o_timeout); end
        checks++; if (o_wid !== 32'h5) begin errors++; $display("FAIL tlbp_hit_index_data got %h expected 00000005", o_wid); end
        checks++; if ({o_wr_index, o_wr_entry} !== 2'b10) begin errors++; $display("FAIL tlbp_hit_strobes got %b expected 10", {o_wr_index, o_wr_entry}); end
        checks++; if (o_hi !== 32'hABCD_E012 || o_kind !== 2'd0 || o_idx !== 4'd0) begin
            errors++; $display("FAIL tlbp_hit_payload got hi %h kind %0d idx %0d expected hi abcde012 kind 0 idx 0", o_hi, o_kind, o_idx); end
        checks++; if ({o_busy_acc, o_busy_mid, o_busy_commit} !== 3'b110) begin
            errors++; $display("FAIL tlbp_hit_busy got %b expected 110", {o_busy_acc, o_busy_mid, o_busy_commit}); end
    endtask

    task automatic test_tlbp_miss();
        run_op(2'd0, 1, 1, 1'b0, 4'd9, 32'h0, 32'h0, 32'h0);
        checks++; if (o_wid !== 32'h8000_0000) begin errors++; $display("FAIL tlbp_miss_index_data got %h expected 80000000", o_wid); end
        checks++; if ({o_wr_index, o_wr_entry} !== 2'b10) begin errors++; $display("FAIL tlbp_miss_strobes got %b expected 10", {o_wr_index, o_wr_entry}); end
        checks++; if (o_done_after) begin errors++; $display("FAIL tlbp_miss_pulse_width got 1 expected 0 after commit"); end
    endtask

    task automatic test_tlbr_stall();
        cp0_entryhi = 32'h1111_2222; cp0_entrylo0 = 32'h3333_4444; cp0_entrylo1 = 32'h5555_6666;
        run_op(2'd1, 4, 0, 1'b0, 4'd0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567);
        checks++; if (!o_stable || o_req_cycles != 5) begin
            errors++; $display("FAIL tlbr_req_stable got stable %0d cycles %0d expected 1 5", o_stable, o_req_cycles); end
        checks++; if (o_hi !== 32'h1111_2222 || o_lo0 !== 32'h3333_4444 || o_lo1 !== 32'h5555_6666) begin
            errors++; $display("FAIL tlbr_payload got %h %h %h expected 11112222 33334444 55556666", o_hi, o_lo0, o_lo1); end
        checks++; if (o_whi !== 32'hDEAD_BEEF || o_wlo0 !== 32'hCAFE_F00D || o_wlo1 !== 32'h0123_4567) begin
            errors++; $display("FAIL tlbr_entry_data got %h %h %h expected deadbeef cafef00d 01234567", o_whi, o_wlo0, o_wlo1); end
        checks++; if ({o_wr_index, o_wr_entry} !== 2'b01 || o_lat != 7) begin
            errors++; $display("FAIL tlbr_commit got strobes %b lat %0d expected 01 7", {o_wr_index, o_wr_entry}, o_lat); end
    endtask

    task automatic test_tlbwr_random();
        bit found = 0;
        // Align so Random is 9 in the acceptance cycle (one cycle after this one).
        for (int c = 0; c < 40; c++) begin
            if (exp_random() == 10) begin found = 1; break; end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL tlbwr_align got no slot expected random 10 within 40 cycles"); end
        run_op(2'd3, 2, 3, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0);
        checks++; if (o_idx !== 4'd9 || !o_stable || o_kind !== 2'd3) begin
            errors++; $display("FAIL tlbwr_req_index got idx %0d stable %0d kind %0d expected 9 1 3", o_idx, o_stable, o_kind); end
        checks++; if (o_rand_commit !== 4'd1) begin errors++; $display("FAIL tlbwr_random_moves got %0d expected 1", o_rand_commit); end
        checks++; if ({o_wr_index, o_wr_entry} !== 2'b00 || o_req_in_wait) begin
            errors++; $display("FAIL tlbwr_no_cp0_write got %b req_in_wait %0d expected 00 0", {o_wr_index, o_wr_entry}, o_req_in_wait); end
    endtask

    task automatic test_wired();
        int lowest = 15;
        @(negedge clk); wired_we = 1'b1; cp0_wired = 4'd6;
        @(negedge clk); wired_we = 1'b0; cp0_wired = 4'd2;
        for (int k = 0; k < 25; k++) begin
            checks++; if (random !== IW'(15 - (k % 10))) begin
                errors++; $display("FAIL wired6_sweep step %0d got %0d expected %0d", k, random, 15 - (k % 10)); end
            if (int'(random) < lowest) lowest = int'(random);
            @(negedge clk);
        end
        checks++; if (lowest != 6) begin errors++; $display("FAIL wired6_floor got %0d expected 6", lowest); end
        wired_we = 1'b1; cp0_wired = 4'd15;
        @(negedge clk); wired_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (random !== 4'd15) begin errors++; $display("FAIL wired15_pin got %0d expected 15", random); end
            @(negedge clk);
        end
        wired_we = 1'b1; cp0_wired = 4'd0;
        @(negedge clk); wired_we = 1'b0;
    endtask

    task automatic test_flush();
        bit saw = 0;
        @(negedge clk); op_valid = 1'b1; op_kind = 2'd2; flush = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 if (tu_bus.req_valid || op_busy) saw = 1;
            @(negedge clk);
        end
        op_valid = 1'b0; flush = 1'b0;
        checks++; if (saw) begin errors++; $display("FAIL flush_blocks got req_valid/op_busy 1 expected 0"); end
    endtask

    task automatic test_reset_in_wait();
        bit saw = 0;
        @(negedge clk); op_valid = 1'b1; op_kind = 2'd1;
        @(negedge clk); op_valid = 1'b0; tu_bus.req_ready = 1'b1;
        @(negedge clk); tu_bus.req_ready = 1'b0;
        checks++; if (!op_busy || tu_bus.req_valid) begin
            errors++; $display("FAIL rstwait_in_wait got busy %0d req_valid %0d expected 1 0", op_busy, tu_bus.req_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({tu_bus.req_valid, op_busy, op_done, wr_index, wr_entry} !== 5'b0 || random !== 4'd15) begin
            errors++; $display("FAIL rstwait_async got %b random %0d expected 00000 15",
                               {tu_bus.req_valid, op_busy, op_done, wr_index, wr_entry}, random); end
        @(negedge clk); reset = 1'b0; tu_bus.resp_valid = 1'b1;
        @(negedge clk); tu_bus.resp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (op_done || wr_entry || wr_index || tu_bus.req_valid) saw = 1;
            @(negedge clk);
        end
        checks++; if (saw) begin errors++; $display("FAIL rstwait_stray_resp got commit activity expected none"); end
    endtask

    task automatic test_random_ops();
        for (int n = 0; n < 12; n++) begin
            logic [1:0] k = 2'($urandom_range(0, 3));
            logic h = 1'($urandom);
            logic [IW-1:0] ri = IW'($urandom);
            logic [31:0] a = $urandom, b = $urandom, d = $urandom;
            int rd = $urandom_range(0, 3), sd = $urandom_range(0, 3);
            cp0_entryhi = $urandom; cp0_entrylo0 = $urandom; cp0_entrylo1 = $urandom;
            cp0_index = IW'($urandom);
            run_op(k, rd, sd, h, ri, a, b, d);
            checks++; if (o_timeout || o_lat != 3 + rd + sd) begin
                errors++; $display("FAIL rnd%0d_latency got %0d expected %0d", n, o_lat, 3 + rd + sd); end
            checks++; if (o_kind !== k || o_idx !== e_idx || o_hi !== e_hi || o_lo0 !== e_lo0 || o_lo1 !== e_lo1) begin
                errors++; $display("FAIL rnd%0d_payload got %0d %0d %h %h %h expected %0d %0d %h %h %h",
                                   n, o_kind, o_idx, o_hi, o_lo0, o_lo1, k, e_idx, e_hi, e_lo0, e_lo1); end
            checks++; if (!o_stable || o_req_cycles != rd + 1 || o_req_in_wait) begin
                errors++; $display("FAIL rnd%0d_handshake got stable %0d cycles %0d wait %0d expected 1 %0d 0",
                                   n, o_stable, o_req_cycles, o_req_in_wait, rd + 1); end
            checks++; if (o_wr_index !== (k == 2'd0) || o_wr_entry !== (k == 2'd1)) begin
                errors++; $display("FAIL rnd%0d_strobes got %b%b for kind %0d", n, o_wr_index, o_wr_entry, k); end
            if (k == 2'd0) begin
                checks++; if (o_wid !== (h ? {28'd0, ri} : 32'h8000_0000)) begin
                    errors++; $display("FAIL rnd%0d_index_data got %h expected %h", n, o_wid, h ? {28'd0, ri} : 32'h8000_0000); end
            end
            if (k == 2'd1) begin
                checks++; if (o_whi !== a || o_wlo0 !== b || o_wlo1 !== d) begin
                    errors++; $display("FAIL rnd%0d_entry_data got %h %h %h expected %h %h %h", n, o_whi, o_wlo0, o_wlo1, a, b, d); end
            end
            checks++; if (o_rand_commit !== IW'(e_rand_commit) || {o_busy_acc, o_busy_mid, o_busy_commit} !== 3'b110 || o_done_after) begin
                errors++; $display("FAIL rnd%0d_misc got random %0d busy %b after %0d expected %0d 110 0",
                                   n, o_rand_commit, {o_busy_acc, o_busy_mid, o_busy_commit}, o_done_after, e_rand_commit); end
        end
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_kind = '0; flush = 1'b0;
        cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0; cp0_index = '0;
        cp0_wired = '0; wired_we = 1'b0;
        tu_bus.req_ready = 1'b0; tu_bus.resp_valid = 1'b0; tu_bus.resp_hit = 1'b0;
        tu_bus.resp_index = '0; tu_bus.resp_entryhi = '0; tu_bus.resp_entrylo0 = '0; tu_bus.resp_entrylo1 = '0;
        test_reset();
        test_tlbp_hit();
        test_tlbp_miss();
        test_tlbr_stall();
        test_tlbwr_random();
        test_wired();
        test_flush();
        test_reset_in_wait();
        test_random_ops();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
